// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, ALUOp encodings and FSM states for the multi-cycle controller
package riscv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] U_TYPE = 7'b0110111;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] HALT   = 7'b0000001;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    // ST_ prefix keeps the HALT state apart from the HALT opcode
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    function automatic logic is_exec_op(input logic [6:0] op);
        return (op == R_TYPE) || (op == I_TYPE) || (op == U_TYPE) ||
               (op == LW) || (op == SW) || (op == BR);
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32 core
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IRWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             Branch,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            op_q      <= 7'd0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= Opcode;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = ALUOP_MEM;
        Branch   = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                state_d = ST_DECODE;
            end
            // op_q is not loaded yet, so DECODE looks at the live IR opcode
            ST_DECODE: begin
                if (Opcode == HALT) begin
                    state_d = ST_HALT;
                end else if (is_exec_op(Opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    R_TYPE: begin
                        ALUOp   = ALUOP_FUNCT;
                        state_d = ST_WB;
                    end
                    I_TYPE: begin
                        ALUOp   = ALUOP_FUNCT;
                        ALUSrc  = 1'b1;
                        state_d = ST_WB;
                    end
                    U_TYPE: begin
                        ALUOp   = ALUOP_LUI;
                        ALUSrc  = 1'b1;
                        state_d = ST_WB;
                    end
                    LW, SW: begin
                        ALUOp   = ALUOP_MEM;
                        ALUSrc  = 1'b1;
                        state_d = ST_MEM;
                    end
                    BR: begin
                        ALUOp   = ALUOP_BR;
                        Branch  = 1'b1;
                        PCWrite = br_taken;
                        PCSrc   = br_taken;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                ALUOp    = ALUOP_MEM;
                ALUSrc   = 1'b1;
                MemRead  = (op_q == LW);
                MemWrite = (op_q == SW);
                if (mem_ready) begin
                    if (op_q == LW) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (op_q == LW);
                ALUSrc   = (op_q != R_TYPE);
                case (op_q)
                    R_TYPE, I_TYPE: ALUOp = ALUOP_FUNCT;
                    U_TYPE:         ALUOp = ALUOP_LUI;
                    default:        ALUOp = ALUOP_MEM;
                endcase
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset silences every output in the same cycle, not only after the edge
        if (reset) begin
            PCWrite  = 1'b0;
            PCSrc    = 1'b0;
            IRWrite  = 1'b0;
            ALUSrc   = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            ALUOp    = ALUOP_MEM;
            Branch   = 1'b0;
            illegal  = 1'b0;
            halted   = 1'b0;
        end
    end

    assign instret = reset ? '0 : instret_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the RV32 core. Sequences fetch, decode, execute, memory and write-back over several cycles so one ALU and one memory port can be shared across phases. Drives the datapath's existing control signals (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) plus the PC and IR write enables. Sits beside the datapath and replaces the single-cycle opcode decoder.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Opcode  in  7  instr[6:0] from the IR; valid from the DECODE cycle onward
- br_taken  in  1  branch condition from the ALU, valid in EXEC
- mem_ready  in  1  data memory completes the current MemRead/MemWrite this cycle
- PCWrite  out  1  PC register load enable
- PCSrc  out  1  0: PC+4; 1: branch target
- IRWrite  out  1  IR and OldPC load enable
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite  out  1 each  same meaning as in the single-cycle datapath
- ALUOp  out  2  00 LW/SW add; 01 branch compare; 10 R/I-type funct decode; 11 LUI pass-through
- Branch  out  1  high in EXEC of a branch instruction
- illegal  out  1  one-cycle pulse in DECODE for an unknown opcode
- halted  out  1  core stopped on HALT (opcode 0000001)
- instret  out  CNT_W  count of retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Opcode is latched into op_q in DECODE. EXEC, MEM and WB decode op_q, not the live Opcode.
- FETCH: IRWrite=1, PCWrite=1, PCSrc=0. Next state DECODE.
- DECODE:
  - HALT opcode → HALT.
  - R (0110011), I (0010011), U (0110111), LW (0000011), SW (0100011), BR (1100011) → EXEC.
  - Any other opcode → illegal=1, instret+1 (treated as a NOP), next FETCH.
- EXEC, R-type: ALUOp=10, ALUSrc=0 → WB.
- EXEC, I-type: ALUOp=10, ALUSrc=1 → WB.
- EXEC, U-type: ALUOp=11, ALUSrc=1 → WB.
- EXEC, LW/SW: ALUOp=00, ALUSrc=1 → MEM.
- EXEC, BR: ALUOp=01, Branch=1. If br_taken, PCWrite=1 and PCSrc=1. instret+1. Next FETCH.
- MEM:
  - LW drives MemRead=1; SW drives MemWrite=1.
  - Held, with ALUOp=00 and ALUSrc=1, until mem_ready=1.
  - On mem_ready: LW → WB; SW → FETCH with instret+1.
  - mem_ready is ignored in every other state.
- WB: RegWrite=1. MemtoReg=1 for LW, else 0. ALUSrc and ALUOp keep their EXEC values. instret+1. Next FETCH.
- HALT: absorbing; halted=1; all other outputs 0. Leaves only on reset.
- Outputs not listed for a state are 0. Outputs are a combinational function of state and op_q (plus br_taken, mem_ready) and are glitch-tolerant at the clock edge.
- instret wraps modulo 2^CNT_W.

## Timing
- Reset:
  - Sampled on a rising edge.
  - Next state is FETCH; op_q=0; instret=0.
  - While reset is high, every output is forced to 0, including halted and illegal.
  - Reset mid-instruction (including during a MEM wait) aborts it. No RegWrite or MemWrite is issued after the reset edge.
- First FETCH outputs appear in the cycle after reset deasserts.
- Cycles per instruction:
  - R/I/U: 4 (FETCH, DECODE, EXEC, WB).
  - BR: 3.
  - SW: 4 + wait cycles.
  - LW: 5 + wait cycles.
  - Illegal: 2.
  - HALT: halted rises 2 cycles after FETCH.
- mem_ready asserted in the first MEM cycle means zero wait cycles. MEM with mem_ready low stays in MEM indefinitely; there is no timeout.
- instret updates at the clock edge that leaves the retiring state, so the new value is visible in the following FETCH.
- RegWrite, MemWrite and PCWrite are each asserted for exactly one cycle per event. The exception is MemWrite, which is held across wait cycles.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode localparams (R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, HALT);
  - ALUOp encodings (ALUOP_MEM, ALUOP_BR, ALUOP_FUNCT, ALUOP_LUI);
  - enum state_t.
- No sub-module: one state register, op_q and instret counter, plus one combinational output block.

## Test plan
- R-type add: reset, Opcode=0110011 → FETCH/DECODE/EXEC/WB. RegWrite=1 only in cycle 4 with ALUOp=10, ALUSrc=0. instret=1 in cycle 5.
- LW with mem_ready low for 3 cycles → MemRead=1 for 4 cycles, then WB with MemtoReg=1 and RegWrite=1. Total 8 cycles.
- BR, br_taken=1 → PCWrite=1 and PCSrc=1 in EXEC (cycle 3); next cycle is FETCH. With br_taken=0: PCWrite=0 in EXEC.
- Opcode changed to garbage during EXEC of an SW → op_q is unaffected; MemWrite is issued and SW retires normally.
- Opcode=1111111 → illegal pulse in DECODE, no RegWrite, instret+1. Then opcode 0000001 → halted=1 permanently; mem_ready and br_taken have no effect.
- Reset asserted in MEM of an SW (mem_ready=0), then mem_ready=1 → no MemWrite after the reset edge. Outputs are 0 while reset is high; the core restarts in FETCH with instret=0.
